// File: rtl/alu_exec_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU, BEQ/BNE resolution and the EX/MEM register.
// Priority at each edge is reset > flush > stall > load; an invalid entry loads as a bubble.
module alu_exec_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [REG_W-1:0]  rd_in,
   input  logic              reg_write_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   output logic              out_valid,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero,
   output logic              branch_taken,
   output logic              illegal_op,
   output logic [DATA_W-1:0] store_data_out,
   output logic [REG_W-1:0]  rd_out,
   output logic              reg_write_out,
   output logic              mem_read_out,
   output logic              mem_write_out
);

   logic [DATA_W-1:0] res;
   logic              taken;
   logic              illegal;
   logic              no_write;
   logic              clear;

   always_comb begin
      res      = '0;
      taken    = 1'b0;
      illegal  = 1'b0;
      no_write = 1'b0;
      case (alu_ctrl)
         4'b0000: res = op_a + op_b;
         4'b0001: res = op_a - op_b;
         4'b0010: res = op_a & op_b;
         4'b0011: res = ~(op_a | op_b);
         4'b0100: res = op_a | op_b;
         4'b0101: res[0] = ($signed(op_a) < $signed(op_b));
         4'b0110: begin
            res      = op_a - op_b;
            taken    = (op_a == op_b);
            no_write = 1'b1;
         end
         4'b0111: begin
            res      = op_a - op_b;
            taken    = (op_a != op_b);
            no_write = 1'b1;
         end
         default: begin
            illegal  = 1'b1;
            no_write = 1'b1;
         end
      endcase
   end

   // A bubble (invalid entry, not stalled) clears the whole register, like a flush.
   assign clear = reset | flush | (~stall & ~in_valid);

   always_ff @(posedge clk) begin
      if (clear) begin
         out_valid      <= 1'b0;
         alu_result     <= '0;
         zero           <= 1'b0;
         branch_taken   <= 1'b0;
         illegal_op     <= 1'b0;
         store_data_out <= '0;
         rd_out         <= '0;
         reg_write_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
      end else if (!stall) begin
         out_valid      <= 1'b1;
         alu_result     <= res;
         zero           <= (res == '0);
         branch_taken   <= taken;
         illegal_op     <= illegal;
         store_data_out <= store_data_in;
         rd_out         <= rd_in;
         reg_write_out  <= reg_write_in & ~no_write;
         mem_read_out   <= mem_read_in  & ~no_write;
         mem_write_out  <= mem_write_in & ~no_write;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed corner cases plus randomized traffic
// compared against a behavioural model of the EX/MEM register.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
   logic [3:0]  alu_ctrl = '0;
   logic [31:0] op_a = '0, op_b = '0, store_data_in = '0;
   logic [4:0]  rd_in = '0;
   logic        reg_write_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
   logic        out_valid, zero, branch_taken, illegal_op;
   logic [31:0] alu_result, store_data_out;
   logic [4:0]  rd_out;
   logic        reg_write_out, mem_read_out, mem_write_out;

   int n_vec = 0;
   int n_err = 0;

   // {out_valid, result, zero, taken, illegal, store, rd, rw, mr, mw}
   logic [75:0] exp_v = '0;
   logic [75:0] exp_m = '1;
   localparam logic [75:0] CTRL_MASK = {1'b1, 32'b0, 1'b0, 1'b1, 1'b1, 32'b0, 5'b0, 3'b111};

   alu_exec_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .store_data_in(store_data_in),
      .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .out_valid(out_valid), .alu_result(alu_result),
      .zero(zero), .branch_taken(branch_taken), .illegal_op(illegal_op),
      .store_data_out(store_data_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
      .mem_read_out(mem_read_out), .mem_write_out(mem_write_out)
   );

   always #5 clk = ~clk;

   function automatic logic [75:0] observed();
      return {out_valid, alu_result, zero, branch_taken, illegal_op, store_data_out,
              rd_out, reg_write_out, mem_read_out, mem_write_out};
   endfunction

   // Reference model: what the EX/MEM register should hold after the coming edge.
   task automatic model_update();
      logic [31:0] r;
      logic        t, ill, br;
      if (reset || flush) begin
         exp_v = '0;
         exp_m = '1;
      end else if (stall) begin
         // hold
      end else if (!in_valid) begin
         exp_v = '0;
         exp_m = CTRL_MASK;
      end else begin
         t   = 1'b0;
         ill = (alu_ctrl >= 4'd8);
         br  = (alu_ctrl == 4'd6) || (alu_ctrl == 4'd7);
         case (alu_ctrl)
            4'd0: r = op_a + op_b;
            4'd1: r = op_a - op_b;
            4'd2: r = op_a & op_b;
            4'd3: r = ~(op_a | op_b);
            4'd4: r = op_a | op_b;
            4'd5: r = (int'(op_a) < int'(op_b)) ? 32'd1 : 32'd0;
            4'd6: begin r = op_a - op_b; t = (op_a == op_b); end
            4'd7: begin r = op_a - op_b; t = (op_a != op_b); end
            default: r = 32'd0;
         endcase
         exp_v = {1'b1, r, (r == 32'd0), t, ill, store_data_in, rd_in,
                  reg_write_in & !(br || ill), mem_read_in & !(br || ill),
                  mem_write_in & !(br || ill)};
         exp_m = '1;
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_payload();
      op_a          = $urandom;
      op_b          = $urandom;
      store_data_in = $urandom;
      rd_in         = 5'($urandom);
      reg_write_in  = 1'($urandom);
      mem_read_in   = 1'($urandom);
      mem_write_in  = 1'($urandom);
      alu_ctrl      = 4'($urandom);
      in_valid      = 1'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b1; flush = 1'b1;
      for (int i = 0; i < 2; i++) begin
         randomize_payload();
         in_valid = 1'b1;
         step();
         n_vec++;
         if (observed() !== 76'd0) begin
            n_err++;
            $display("FAIL reset cycle %0d: got %h, want 0", i, observed());
         end
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_alu_directed();
      logic [3:0]  c [12] = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd5, 4'd5, 4'd6, 4'd7, 4'd7,
                              4'd2, 4'd4, 4'd6};
      logic [31:0] a [12] = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd1,
                              32'h7FFFFFFF, 32'd3, 32'd3, 32'd3, 32'hF0F0, 32'hF000, 32'd4};
      logic [31:0] b [12] = '{32'd1, 32'd5, 32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000,
                              32'd3, 32'd3, 32'd4, 32'hFF00, 32'h000F, 32'd3};
      logic [31:0] er[12] = '{32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hF000, 32'hF00F, 32'd1};
      logic        et[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; alu_ctrl = c[i]; op_a = a[i]; op_b = b[i];
         reg_write_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
         store_data_in = $urandom; rd_in = 5'($urandom);
         step();
         n_vec++;
         if (alu_result !== er[i] || branch_taken !== et[i] || zero !== (er[i] == 0) ||
             reg_write_out !== (c[i] < 4'd6) || (observed() & exp_m) !== (exp_v & exp_m)) begin
            n_err++;
            $display("FAIL directed %0d code %0d: result %h taken %b zero %b rw %b, want %h %b %b %b",
                     i, c[i], alu_result, branch_taken, zero, reg_write_out,
                     er[i], et[i], (er[i] == 0), (c[i] < 4'd6));
         end
      end
   endtask

   task automatic test_stall_flush();
      in_valid = 1'b1; alu_ctrl = 4'd0; op_a = 32'h1000; op_b = 32'h24;
      reg_write_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
      rd_in = 5'd9; store_data_in = 32'hDEADBEEF;
      step();
      n_vec++;
      if (alu_result !== 32'h1024 || mem_read_out !== 1'b1 || rd_out !== 5'd9) begin
         n_err++;
         $display("FAIL lw load: addr %h mr %b rd %0d, want 1024 1 9",
                  alu_result, mem_read_out, rd_out);
      end
      for (int i = 0; i < 4; i++) begin
         randomize_payload();
         stall = 1'b1;
         flush = (i == 3);
         step();
         n_vec++;
         if ((observed() & exp_m) !== (exp_v & exp_m) || (i < 3 && alu_result !== 32'h1024)
             || (i == 3 && out_valid !== 1'b0)) begin
            n_err++;
            $display("FAIL stall/flush %0d: got %h, want %h", i, observed(), exp_v);
         end
      end
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_illegal();
      for (int i = 0; i < 2; i++) begin
         in_valid = (i == 0); alu_ctrl = 4'b1010; op_a = $urandom; op_b = $urandom;
         reg_write_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b1;
         step();
         n_vec++;
         if (illegal_op !== (i == 0) || reg_write_out !== 1'b0 || mem_write_out !== 1'b0 ||
             mem_read_out !== 1'b0 || (i == 0 && alu_result !== 32'd0)) begin
            n_err++;
            $display("FAIL illegal valid=%0d: ill %b result %h rw %b, want %b 0 0",
                     in_valid, illegal_op, alu_result, reg_write_out, (i == 0));
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         randomize_payload();
         if ($urandom_range(0, 3) == 0) alu_ctrl = 4'($urandom_range(6, 7));
         if ($urandom_range(0, 3) == 0) op_b = op_a;
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 29) == 0);
         step();
         n_vec++;
         if ((observed() & exp_m) !== (exp_v & exp_m)) begin
            n_err++;
            $display("FAIL random %0d: got %h, want %h (mask %h)", i, observed(), exp_v, exp_m);
         end
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu_directed();
      test_stall_flush();
      test_illegal();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
